// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot/indexed grant and ready/valid handshake.
// Define RR_ARBITER_PENDING_EN to latch requests in a pending register until granted.
module rr_arbiter #(
    parameter int unsigned IP_WIDTH = 4,
    localparam int unsigned OP_SIZE = $clog2(IP_WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [IP_WIDTH-1:0] req,
    input  logic                gnt_ready,
    output logic                gnt_valid,
    output logic [IP_WIDTH-1:0] gnt,
    output logic [OP_SIZE-1:0]  gnt_idx
);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic [IP_WIDTH-1:0] gnt_q, gnt_d;
    logic [OP_SIZE-1:0]  idx_q, idx_d;
    logic [OP_SIZE-1:0]  ptr_q, ptr_d;
    logic [IP_WIDTH-1:0] eff_req;
    logic                sel_found;
    logic [OP_SIZE-1:0]  sel_idx;

`ifdef RR_ARBITER_PENDING_EN
    logic [IP_WIDTH-1:0] pending_q, pending_d;
    logic [IP_WIDTH-1:0] clr;

    // A new request on the bit being cleared wins, so it is not lost.
    always_comb begin
        clr       = (valid_q && gnt_ready) ? gnt_q : '0;
        pending_d = (pending_q & ~clr) | req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign eff_req = pending_q;
`else
    assign eff_req = req;
`endif

    // First set request searching upward from ptr, wrapping to 0.
    always_comb begin
        int unsigned j;
        logic [OP_SIZE-1:0] jj;
        j         = 0;
        jj        = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < IP_WIDTH; i++) begin
            j  = (32'(ptr_q) + i) % IP_WIDTH;
            jj = OP_SIZE'(j);
            if (!sel_found && eff_req[jj]) begin
                sel_found = 1'b1;
                sel_idx   = jj;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                gnt_d   = '0;
                if (en && sel_found) begin
                    gnt_d[sel_idx] = 1'b1;
                    idx_d          = sel_idx;
                    valid_d        = 1'b1;
                    state_d        = StGrant;
                end
            end
            StGrant: begin
                if (gnt_ready) begin
                    valid_d = 1'b0;
                    gnt_d   = '0;
                    ptr_d   = (idx_q == OP_SIZE'(IP_WIDTH - 1)) ? '0 : idx_q + OP_SIZE'(1);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt_valid = valid_q;
    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed scenarios plus random traffic
// compared against a cycle-level round-robin reference model.
module tb_rr_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] req;
    logic         gnt_ready;
    logic         gnt_valid;
    logic [W-1:0] gnt;
    logic [1:0]   gnt_idx;

    int checks = 0;
    int errors = 0;

    // Reference model: busy flag, granted index, rotating start point, pending set.
    bit m_busy;
    int m_idx;
    int m_ptr;
    bit m_pend [W];

    rr_arbiter #(.IP_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt_ready (gnt_ready),
        .gnt_valid (gnt_valid),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy = 0;
        m_idx  = 0;
        m_ptr  = 0;
        for (int i = 0; i < W; i++) m_pend[i] = 0;
    endtask

    task automatic model_clock();
        bit hs;
        int old_idx;
        bit done;
        bit wants;
        int c;
        hs      = m_busy && gnt_ready;
        old_idx = m_idx;
        done    = 0;
        if (m_busy) begin
            if (gnt_ready) begin
                m_busy = 0;
                m_ptr  = (m_idx + 1) % W;
            end
        end else if (en) begin
            for (int k = 0; k < W; k++) begin
                c = (m_ptr + k) % W;
`ifdef RR_ARBITER_PENDING_EN
                wants = m_pend[c];
`else
                wants = req[c];
`endif
                if (!done && wants) begin
                    done   = 1;
                    m_busy = 1;
                    m_idx  = c;
                end
            end
        end
        for (int i = 0; i < W; i++)
            m_pend[i] = (m_pend[i] && !(hs && i == old_idx)) || req[i];
    endtask

    // One clock: drive inputs, advance the model on the edge, compare on the falling edge.
    task automatic step(input bit e, input logic [W-1:0] r, input bit rd);
        logic [W-1:0] exp_gnt;
        en = e;
        req = r;
        gnt_ready = rd;
        @(posedge clk);
        model_clock();
        @(negedge clk);
        exp_gnt = m_busy ? (W'(1) << m_idx) : '0;
        checks++;
        if (gnt_valid !== m_busy) begin
            errors++;
            $display("FAIL model_valid: got %b expected %b at %0t", gnt_valid, m_busy, $time);
        end
        checks++;
        if (gnt !== exp_gnt) begin
            errors++;
            $display("FAIL model_gnt: got %b expected %b at %0t", gnt, exp_gnt, $time);
        end
        checks++;
        if (gnt_idx !== 2'(m_idx)) begin
            errors++;
            $display("FAIL model_idx: got %0d expected %0d at %0t", gnt_idx, m_idx, $time);
        end
        if (gnt_valid === 1'b1) begin
            checks++;
            if (!$onehot(gnt) || gnt[gnt_idx] !== 1'b1) begin
                errors++;
                $display("FAIL onehot: gnt %b idx %0d at %0t", gnt, gnt_idx, $time);
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        en = 1'b0;
        req = '0;
        gnt_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_grant(input bit e, input logic [W-1:0] r, input bit rd, input int max);
        bit ok;
        ok = 0;
        for (int i = 0; i < max && !ok; i++) begin
            step(e, r, rd);
            ok = (gnt_valid === 1'b1);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL grant_timeout: no grant within %0d cycles, req %b", max, r);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (gnt_valid !== 1'b0 || gnt !== 4'b0000 || gnt_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_values: valid %b gnt %b idx %0d", gnt_valid, gnt, gnt_idx);
        end
        wait_grant(1, 4'b0100, 0, 4);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (gnt_valid !== 1'b0 || gnt !== 4'b0000 || gnt_idx !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: valid %b gnt %b idx %0d", gnt_valid, gnt, gnt_idx);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_grant(1, 4'b1111, 1, 4);
        checks++;
        if (gnt_idx !== 2'd0 || gnt !== 4'b0001) begin
            errors++;
            $display("FAIL reset_restart: idx %0d gnt %b, expected 0 / 0001", gnt_idx, gnt);
        end
    endtask

    task automatic test_round_robin();
        int got[$];
        int exp_seq[5];
        bit prev_valid;
        int back_to_back;
        exp_seq = '{0, 1, 2, 3, 0};
        prev_valid = 0;
        back_to_back = 0;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            step(1, 4'b1111, 1);
            if (gnt_valid === 1'b1) begin
                got.push_back(int'(gnt_idx));
                if (prev_valid) back_to_back++;
            end
            prev_valid = (gnt_valid === 1'b1);
        end
        checks++;
        if (got.size() < 5) begin
            errors++;
            $display("FAIL rr_count: got %0d grants, expected at least 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] != exp_seq[i]) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got %0d expected %0d", i, got[i], exp_seq[i]);
                end
            end
        end
        checks++;
        if (back_to_back != 0) begin
            errors++;
            $display("FAIL rr_spacing: %0d grants without an idle cycle, expected 0", back_to_back);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        wait_grant(1, 4'b1000, 1, 4);
        checks++;
        if (gnt_idx !== 2'd3) begin
            errors++;
            $display("FAIL wrap_first: idx %0d expected 3", gnt_idx);
        end
        step(1, 4'b1001, 1);
        wait_grant(1, 4'b1001, 1, 4);
        checks++;
        if (gnt_idx !== 2'd0 || gnt !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_next: idx %0d gnt %b expected 0 / 0001", gnt_idx, gnt);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        wait_grant(1, 4'b0010, 0, 4);
        for (int i = 0; i < 5; i++) begin
            step(bit'($urandom_range(0, 1)), W'($urandom), 0);
            checks++;
            if (gnt_valid !== 1'b1 || gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
                errors++;
                $display("FAIL hold[%0d]: valid %b gnt %b idx %0d", i, gnt_valid, gnt, gnt_idx);
            end
        end
        step(1, 4'b0000, 1);
        checks++;
        if (gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: valid %b expected 0", gnt_valid);
        end
    endtask

    task automatic test_enable();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 4'b0100, 1);
            checks++;
            if (gnt_valid !== 1'b0) begin
                errors++;
                $display("FAIL en_block[%0d]: valid %b expected 0", i, gnt_valid);
            end
        end
        step(1, 4'b0100, 1);
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 2'd2) begin
            errors++;
            $display("FAIL en_raise: valid %b idx %0d expected 1 / 2", gnt_valid, gnt_idx);
        end
    endtask

    task automatic test_pulse();
        bit saw2;
        bit exp_saw2;
`ifdef RR_ARBITER_PENDING_EN
        exp_saw2 = 1;
`else
        exp_saw2 = 0;
`endif
        saw2 = 0;
        apply_reset();
        wait_grant(1, 4'b0001, 0, 4);
        step(1, 4'b0100, 0);
        step(1, 4'b0000, 0);
        step(1, 4'b0000, 1);
        for (int i = 0; i < 8; i++) begin
            step(1, 4'b0000, 1);
            if (gnt_valid === 1'b1 && gnt_idx === 2'd2) saw2 = 1;
        end
        checks++;
        if (saw2 != exp_saw2) begin
            errors++;
            $display("FAIL pulse_grant: idx2 granted %b expected %b", saw2, exp_saw2);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 7) != 0, W'($urandom), bit'($urandom_range(0, 1)));
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        req = '0;
        gnt_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_enable();
        test_pulse();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
